avr_intc: RTL and testbench

Eight-source interrupt controller for the AVR core, the responder on the core's `intr`/`vect` inputs and a slave on its data bus. It edge-detects external event lines, latches them as pending, masks them and presents the highest-priority pending source as a level `intr` with a 3-bit `vect`. Software reads status and clears or sets pending bits through four memory-mapped byte registers in the core's data space.

---
 rtl/avr_intc.sv | 160 ++++++++++++++++
 tb/tb_avr_intc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_intc.sv
// avr_intc -- eight-source interrupt controller for the AVR core.
//
// Rising edges on src latch pending bits. Pending bits are masked, and the
// lowest-numbered active source is presented to the core as a registered
// level intr with a 3-bit vect. Four byte registers in data space are
// decoded from BASE:
//   BASE+0 PEND   read pending, write-1-to-clear
//   BASE+1 MASK   read/write, 1 = source enabled
//   BASE+2 STAT   read-only {intr, 4'b0, vect}
//   BASE+3 SWTRIG write-1-to-set pending, reads as 0
//
// Parameters:
//   BASE  data-space address of PEND
//   SYNC  1 = two-flop synchronizer ahead of the edge detector
//
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   src      event lines, rising edge on bit n requests interrupt n
//   address  core data address
//   data_i   write data from the core
//   we       core write strobe, qualified by address
//   data_o   combinational read data, 0 when sel = 0
//   sel      combinational, address is within BASE..BASE+3
//   intr     registered interrupt request
//   vect     registered index of the granted source

module avr_intc #(
  parameter logic [15:0] BASE = 16'h0050,
  parameter bit          SYNC = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  src,
  input  logic [15:0] address,
  input  logic [7:0]  data_i,
  input  logic        we,
  output logic [7:0]  data_o,
  output logic        sel,
  output logic        intr,
  output logic [2:0]  vect
);

  logic [7:0]  s_in;
  logic [7:0]  s;
  logic [7:0]  s_d;
  logic [7:0]  edge_det;
  logic [7:0]  pend;
  logic [7:0]  pend_next;
  logic [7:0]  mask;
  logic [7:0]  active;
  logic [7:0]  w1c;
  logic [7:0]  swtrig;
  logic [15:0] offset;
  logic        wr_pend;
  logic        wr_mask;
  logic        wr_swtrig;
  logic [2:0]  grant;

  // Input conditioning. The source sample s is always registered, so the
  // synchronizer (when present) adds two stages ahead of it.
  generate
    if (SYNC) begin : g_sync
      logic [7:0] meta_a;
      logic [7:0] meta_b;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          meta_a <= '0;
          meta_b <= '0;
        end else begin
          meta_a <= src;
          meta_b <= meta_a;
        end
      end

      assign s_in = meta_b;
    end else begin : g_nosync
      assign s_in = src;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s   <= '0;
      s_d <= '0;
    end else begin
      s   <= s_in;
      s_d <= s;
    end
  end

  assign edge_det = s & ~s_d;

  // Address decode. The subtraction wraps for addresses below BASE, so a
  // single unsigned compare covers both ends of the window.
  assign offset    = address - BASE;
  assign sel       = (offset < 16'd4);
  assign wr_pend   = we && sel && (offset[1:0] == 2'd0);
  assign wr_mask   = we && sel && (offset[1:0] == 2'd1);
  assign wr_swtrig = we && sel && (offset[1:0] == 2'd3);

  assign w1c    = wr_pend   ? data_i : '0;
  assign swtrig = wr_swtrig ? data_i : '0;

  // Set terms are ORed in after the clear, so a same-cycle edge or software
  // trigger wins over a W1C of the same bit.
  assign pend_next = (pend & ~w1c) | edge_det | swtrig;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= pend_next;
      if (wr_mask) begin
        mask <= data_i;
      end
    end
  end

  // Fixed priority, bit 0 highest.
  assign active = pend & mask;

  always_comb begin
    grant = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (active[i-1]) begin
        grant = 3'(i - 1);
      end
    end
  end

  // vect holds its last grant while nothing is active.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      intr <= 1'b0;
      vect <= '0;
    end else begin
      intr <= (active != '0);
      if (active != '0) begin
        vect <= grant;
      end
    end
  end

  // Read mux; reflects pre-write state in a write cycle.
  always_comb begin
    data_o = '0;
    if (sel) begin
      unique case (offset[1:0])
        2'd0:    data_o = pend;
        2'd1:    data_o = mask;
        2'd2:    data_o = {intr, 4'b0000, vect};
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_intc.sv
// Testbench for avr_intc (SYNC = 1). A cycle-level reference model tracks
// pending, mask and the granted request from the register-level rules and a
// short history of sampled src values; directed scenarios are followed by a
// randomized phase and a reset-during-request scenario.

module tb_avr_intc;

  localparam logic [15:0] BASE = 16'h0050;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  src     = '0;
  logic [15:0] address = '0;
  logic [7:0]  data_i  = '0;
  logic        we      = 1'b0;
  logic [7:0]  data_o;
  logic        sel;
  logic        intr;
  logic [2:0]  vect;

  always #5 clock = ~clock;

  avr_intc #(.BASE(BASE), .SYNC(1'b1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .src     (src),
    .address (address),
    .data_i  (data_i),
    .we      (we),
    .data_o  (data_o),
    .sel     (sel),
    .intr    (intr),
    .vect    (vect)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state. hist[0] is the src value sampled at the most
  // recent clock edge, hist[3] the one sampled four edges ago.
  logic [7:0] m_pend;
  logic [7:0] m_mask;
  logic       m_intr;
  logic [2:0] m_vect;
  logic [7:0] hist [4];

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    if (off == 16'd0) return m_pend;
    if (off == 16'd1) return m_mask;
    if (off == 16'd2) return {m_intr, 4'b0000, m_vect};
    return 8'h00;
  endfunction

  function automatic logic m_sel(input logic [15:0] a);
    return (a >= BASE) && (a <= BASE + 16'd3);
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge, then
  // compare outputs and the read port at the current address.
  task automatic step();
    logic [7:0]  edge_v;
    logic [7:0]  w1c;
    logic [7:0]  sw;
    logic [7:0]  act;
    logic [7:0]  smp;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    // A rise first sampled at edge E0 is seen as an edge at E0+3.
    edge_v = hist[2] & ~hist[3];
    smp = src;
    wr  = we;
    a   = address;
    d   = data_i;
    w1c = (wr && a == BASE)          ? d : 8'h00;
    sw  = (wr && a == BASE + 16'd3)  ? d : 8'h00;
    act = m_pend & m_mask;
    @(posedge clock);
    if (act != 8'h00) begin
      m_intr = 1'b1;
      for (int i = 7; i >= 0; i--) begin
        if (act[i]) m_vect = 3'(i);
      end
    end else begin
      m_intr = 1'b0;
    end
    if (wr && a == BASE + 16'd1) m_mask = d;
    m_pend = (m_pend & ~w1c) | edge_v | sw;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = smp;
    #1;
    cmp("intr", 16'(intr), 16'(m_intr));
    cmp("vect", 16'(vect), 16'(m_vect));
    cmp("data_o", 16'(data_o), 16'(m_read(address)));
    cmp("sel", 16'(sel), 16'(m_sel(address)));
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
    address = a;
    data_i  = d;
    we      = 1'b1;
    step();
    we      = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] hold_src);
    src = hold_src;
    we  = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    cmp("rst_intr_async", 16'(intr), 16'h0000);
    cmp("rst_vect_async", 16'(vect), 16'h0000);
    m_pend = '0;
    m_mask = '0;
    m_intr = 1'b0;
    m_vect = '0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state.
    do_reset(8'h00);
    address = BASE;
    #1;
    cmp("rst_pend", 16'(data_o), 16'h0000);
    address = BASE + 16'd1;
    #1;
    cmp("rst_mask", 16'(data_o), 16'h0000);
    address = BASE + 16'd2;
    #1;
    cmp("rst_stat", 16'(data_o), 16'h0000);
    step();

    // Latency through the synchronizer, and no re-trigger on a held level.
    wr_reg(BASE + 16'd1, 8'h04);
    address = BASE;
    src[2] = 1'b1;
    step();                              // E0
    step();                              // E1
    step();                              // E2
    cmp("lat_pend_e2", 16'(data_o), 16'h0000);
    step();                              // E3
    cmp("lat_pend_e3", 16'(data_o), 16'h0004);
    cmp("lat_intr_e3", 16'(intr), 16'h0000);
    step();                              // E4
    cmp("lat_intr_e4", 16'(intr), 16'h0001);
    cmp("lat_vect_e4", 16'(vect), 16'h0002);
    wr_reg(BASE, 8'h04);
    repeat (6) step();
    cmp("hold_no_retrig_pend", 16'(data_o), 16'h0000);
    cmp("hold_no_retrig_intr", 16'(intr), 16'h0000);
    src[2] = 1'b0;
    repeat (4) step();

    // Priority.
    wr_reg(BASE + 16'd1, 8'hFF);
    wr_reg(BASE + 16'd3, 8'hA0);
    step();
    cmp("prio_vect5", 16'(vect), 16'h0005);
    cmp("prio_intr5", 16'(intr), 16'h0001);
    wr_reg(BASE, 8'h20);
    step();
    cmp("prio_vect7", 16'(vect), 16'h0007);
    cmp("prio_intr7", 16'(intr), 16'h0001);
    wr_reg(BASE, 8'h80);
    step();
    cmp("prio_intr_off", 16'(intr), 16'h0000);
    cmp("prio_vect_hold", 16'(vect), 16'h0007);

    // Masking: pending latches while masked, unmask raises intr.
    wr_reg(BASE + 16'd1, 8'h00);
    address = BASE;
    src[3] = 1'b1;
    repeat (5) step();
    cmp("mask_pend", 16'(data_o), 16'h0008);
    cmp("mask_intr_off", 16'(intr), 16'h0000);
    wr_reg(BASE + 16'd1, 8'h08);
    step();
    cmp("unmask_intr", 16'(intr), 16'h0001);
    cmp("unmask_vect", 16'(vect), 16'h0003);
    src[3] = 1'b0;
    wr_reg(BASE, 8'h08);
    repeat (2) step();

    // Collision: W1C lands on the same edge that sets bit 1.
    src[1] = 1'b1;
    address = BASE;
    step();                              // E0
    step();                              // E1
    step();                              // E2
    wr_reg(BASE, 8'h02);                 // E3
    address = BASE;
    #1;
    cmp("collide_pend", 16'(data_o & 8'h02), 16'h0002);
    src[1] = 1'b0;
    wr_reg(BASE, 8'hFF);
    step();

    // Decode window edges.
    wr_reg(BASE + 16'd4, 8'hFF);
    cmp("dec_hi_sel", 16'(sel), 16'h0000);
    cmp("dec_hi_data", 16'(data_o), 16'h0000);
    wr_reg(BASE - 16'd1, 8'hFF);
    cmp("dec_lo_sel", 16'(sel), 16'h0000);
    cmp("dec_lo_data", 16'(data_o), 16'h0000);
    address = BASE + 16'd1;
    #1;
    cmp("dec_mask_kept", 16'(data_o), 16'h0008);
    address = BASE + 16'd3;
    #1;
    cmp("swtrig_reads0", 16'(data_o), 16'h0000);
    step();

    // Randomized traffic around the register window.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) src = src ^ 8'($urandom_range(0, 255));
      we      = ($urandom_range(0, 2) == 0);
      address = BASE - 16'd2 + 16'($urandom_range(0, 7));
      data_i  = 8'($urandom_range(0, 255));
      step();
    end
    we = 1'b0;
    src = '0;
    repeat (6) step();

    // Reset while a request is up; intr must drop without a clock edge.
    wr_reg(BASE + 16'd1, 8'hFF);
    wr_reg(BASE + 16'd3, 8'h01);
    step();
    cmp("pre_rst_intr", 16'(intr), 16'h0001);
    do_reset(8'h10);
    address = BASE;
    #1;
    cmp("post_rst_pend", 16'(data_o), 16'h0000);

    // A source held high through reset release produces exactly one edge.
    repeat (8) step();
    cmp("held_one_edge", 16'(data_o), 16'h0010);
    wr_reg(BASE, 8'h10);
    repeat (6) step();
    cmp("held_no_second", 16'(data_o), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
